// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
// Requests are latched, executed in a single EXEC cycle and returned on a tagged response channel.
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [4:0]       req0_uc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [4:0]       req1_uc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [4:0] UC_AND   = 5'b00000;
    localparam logic [4:0] UC_OR    = 5'b00001;
    localparam logic [4:0] UC_SUM   = 5'b00010;
    localparam logic [4:0] UC_RESTA = 5'b00011;
    localparam logic [4:0] UC_XOR   = 5'b00100;

    state_t           state, state_nx;
    logic             last_grant;
    logic             grant0, grant1;
    logic             hs0, hs1;
    logic [WIDTH-1:0] op_a, op_b;
    logic [4:0]       op_uc;
    logic             op_id;

    logic [WIDTH-1:0] alu_result;
    logic [WIDTH:0]   alu_ext;
    logic             alu_n, alu_z, alu_c, alu_v, alu_err;

    // Round-robin: on contention the port that did not win last time is granted.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
    end

    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;
    assign hs0        = req0_valid & req0_ready;
    assign hs1        = req1_valid & req1_ready;
    assign rsp_valid  = (state == RESP);

    always_comb begin
        alu_result = '0;
        alu_ext    = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_err    = 1'b0;
        case (op_uc)
            UC_AND: alu_result = op_a & op_b;
            UC_OR:  alu_result = op_a | op_b;
            UC_XOR: alu_result = op_a ^ op_b;
            UC_SUM: begin
                alu_ext    = {1'b0, op_a} + {1'b0, op_b};
                alu_result = alu_ext[WIDTH-1:0];
                alu_c      = alu_ext[WIDTH];
                alu_v      = (op_a[WIDTH-1] == op_b[WIDTH-1]) &
                             (alu_result[WIDTH-1] != op_a[WIDTH-1]);
            end
            UC_RESTA: begin
                alu_ext    = {1'b0, op_a} - {1'b0, op_b};
                alu_result = alu_ext[WIDTH-1:0];
                alu_c      = ~alu_ext[WIDTH];
                alu_v      = (op_a[WIDTH-1] != op_b[WIDTH-1]) &
                             (alu_result[WIDTH-1] != op_a[WIDTH-1]);
            end
            default: alu_err = 1'b1;
        endcase
        // Unknown opcodes report all-zero flags, including z.
        alu_n = ~alu_err & alu_result[WIDTH-1];
        alu_z = ~alu_err & (alu_result == '0);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (hs0 | hs1) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_uc      <= '0;
            op_id      <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (hs0 | hs1) begin
                op_a       <= hs1 ? req1_a  : req0_a;
                op_b       <= hs1 ? req1_b  : req0_b;
                op_uc      <= hs1 ? req1_uc : req0_uc;
                op_id      <= hs1;
                last_grant <= hs1;
            end
            if (state == EXEC) begin
                rsp_id     <= op_id;
                rsp_result <= alu_result;
                rsp_flags  <= {alu_n, alu_z, alu_c, alu_v};
                rsp_err    <= alu_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
// Transaction-level reference model plus directed and randomized stimulus.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [4:0] req0_uc = '0, req1_uc = '0;
    logic       rsp_valid, rsp_id, rsp_err;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_result, rsp_flags;

    alu_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_uc(req0_uc),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_uc(req1_uc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    // Returns {err, n, z, c, v, result[3:0]} computed with plain integer arithmetic.
    function automatic logic [8:0] ref_alu(input int a, input int b, input int uc);
        int r, sr;
        logic c, v, n, z;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (uc)
            0: r = a & b;
            1: r = a | b;
            4: r = a ^ b;
            2: begin
                r  = a + b;
                c  = (r > 15);
                sr = sgn(a) + sgn(b);
                v  = (sr > 7) || (sr < -8);
                r  = r % 16;
            end
            3: begin
                r  = a - b;
                c  = (a >= b);
                sr = sgn(a) - sgn(b);
                v  = (sr > 7) || (sr < -8);
                r  = (r + 16) % 16;
            end
            default: return 9'h100;
        endcase
        n = (r >= 8);
        z = (r == 0);
        return {1'b0, n, z, c, v, 4'(r)};
    endfunction

    // Reference model: at most one op in flight; response visible from the second edge after acceptance.
    int         cyc = 0;
    int         m_t = 0;
    bit         m_busy = 1'b0;
    bit         m_last = 1'b1;
    bit         m_id = 1'b0;
    logic [8:0] m_exp = '0;
    bit         g0, g1;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (m_busy) begin
            if (cyc > m_t + 1 && rsp_ready) m_busy = 1'b0;
        end else begin
            g0 = req0_valid && (!req1_valid || m_last);
            g1 = req1_valid && (!req0_valid || !m_last);
            if (g0 || g1) begin
                m_busy = 1'b1;
                m_t    = cyc;
                m_id   = g1;
                m_last = g1;
                m_exp  = g1 ? ref_alu(req1_a, req1_b, req1_uc) : ref_alu(req0_a, req0_b, req0_uc);
            end
        end
    end

    bit         acc0 = 1'b0, acc1 = 1'b0;
    bit         e_valid, e_r0, e_r1;
    bit         id_q[$];
    logic [3:0] last_res = '0, last_flags = '0;
    logic       last_id = 1'b0, last_err = 1'b0;

    always @(negedge clk) begin
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        if (!rst_n) begin
            chk("reset_outputs", {rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, req0_ready, req1_ready}, 0);
        end else begin
            e_valid = m_busy && (cyc >= m_t + 1);
            e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
            e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("rsp_valid", rsp_valid, e_valid);
            if (e_valid) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_result", rsp_result, m_exp[3:0]);
                chk("rsp_flags", rsp_flags, m_exp[7:4]);
                chk("rsp_err", rsp_err, m_exp[8]);
            end
            if (rsp_valid && rsp_ready) begin
                id_q.push_back(rsp_id);
                last_res   = rsp_result;
                last_flags = rsp_flags;
                last_id    = rsp_id;
                last_err   = rsp_err;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        step();
        while (m_busy && n < 60) begin
            step();
            n++;
        end
        chk("idle_timeout", (n < 60), 1);
    endtask

    task automatic do_op(input bit p, input logic [3:0] a, input logic [3:0] b, input logic [4:0] uc);
        int n = 0;
        if (p) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_uc = uc;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_uc = uc;
        end
        step();
        while (!(p ? acc1 : acc0) && n < 20) begin
            step();
            n++;
        end
        chk("handshake_timeout", (n < 20), 1);
        if (p) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    int qn;

    initial begin
        chk("model_sum", ref_alu(7, 1, 2), {1'b0, 4'b1001, 4'b1000});
        chk("model_resta", ref_alu(3, 3, 3), {1'b0, 4'b0110, 4'b0000});
        chk("model_invalid", ref_alu(15, 15, 31), 9'h100);
        chk("model_resta_ovf", ref_alu(8, 1, 3), {1'b0, 4'b0011, 4'b0111});

        repeat (3) step();
        rst_n = 1'b1;
        step();

        rsp_ready = 1'b1;
        do_op(0, 4'b0111, 4'b0001, 5'b00010);
        wait_idle();
        chk("t1_result", last_res, 4'b1000);
        chk("t1_flags", last_flags, 4'b1001);
        chk("t1_id_err", {last_id, last_err}, 2'b00);

        do_op(1, 4'b0011, 4'b0011, 5'b00011);
        wait_idle();
        chk("t2_result", last_res, 4'b0000);
        chk("t2_flags", last_flags, 4'b0110);
        chk("t2_id", last_id, 1'b1);

        id_q.delete();
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_uc = 5'd2;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd9; req1_uc = 5'd1;
        repeat (14) step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        qn = id_q.size();
        chk("t3_count", (qn >= 4), 1);
        if (qn >= 4) chk("t3_ids", {id_q[0], id_q[1], id_q[2], id_q[3]}, 4'b0101);

        rsp_ready = 1'b0;
        do_op(0, 4'd5, 4'd6, 5'd4);
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd4; req1_uc = 5'd0;
        repeat (6) step();
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        chk("t4_result", last_res, 4'b0011);

        do_op(0, 4'b1111, 4'b1111, 5'b11111);
        wait_idle();
        chk("t5_invalid", {last_err, last_flags, last_res}, 9'h100);
        do_op(0, 4'd2, 4'd3, 5'd2);
        wait_idle();
        chk("t5_next", {last_err, last_flags, last_res}, {1'b0, 4'b0000, 4'b0101});

        qn = id_q.size();
        do_op(0, 4'd1, 4'd1, 5'd2);
        rst_n = 1'b0;
        step();
        step();
        chk("t6_no_rsp", id_q.size(), qn);
        id_q.delete();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd4; req0_uc = 5'd2;
        req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd1; req1_uc = 5'd3;
        qn = 0;
        while (id_q.size() == 0 && qn < 20) begin
            step();
            qn++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("t6_first_id", (id_q.size() > 0) ? {1'b0, id_q[0]} : 2'b10, 2'b00);
        wait_idle();

        for (int i = 0; i < 3000; i++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom % 3) != 0;
                req0_a  = 4'($urandom);
                req0_b  = 4'($urandom);
                req0_uc = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom % 5);
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom % 3) != 0;
                req1_a  = 4'($urandom);
                req1_b  = 4'($urandom);
                req1_uc = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom % 5);
            end
            rsp_ready = ($urandom % 4) != 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
